// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache request sequencer and the set it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int LINE_WIDTH_DEF = 32;
   localparam int K_DEF          = 2;

   typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
   typedef logic [LINE_WIDTH_DEF-1:0] val_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_CHECK,
      ST_MEM_RD,
      ST_FILL,
      ST_MEM_WR,
      ST_RESP
   } ctrl_state_t;

   // A full CLOCK sweep can touch every way twice before a victim is free,
   // plus a few cycles of install/hit-report slack.
   function automatic int fill_timeout_def(input int k);
      return 2 * k + 4;
   endfunction

endpackage

// File: rtl/cache_sat_ctr.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count visible the cycle after inc_i.
// Backpressure: none.
// Ports: clk_i, rst_i (async, active-high), clr_i (sync clear), inc_i, cnt_o.
module cache_sat_ctr #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_req_ctrl.sv
// Request sequencer in front of one K-way CLOCK cache set: lookup, miss refill, write-through.
// Latency: read hit responds 3 cycles after accept; misses/writes depend on memory and eviction.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
// Ports: req_* (requester in), resp_* (response out), set_* (cache set strobes/data),
//        mem_* (backing memory, req held until one-cycle ack), clock/reset (async, active-high).
// Optional: define CACHE_REQ_STATS_EN to add stat_hits/stat_misses/stat_timeouts outputs.
module cache_req_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int LINE_WIDTH   = LINE_WIDTH_DEF,
   parameter int K            = K_DEF,
   parameter int FILL_TIMEOUT = fill_timeout_def(K)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LINE_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [LINE_WIDTH-1:0] resp_rdata,
   output logic                  resp_hit,
   output logic                  resp_err,
   output logic                  set_enable,
   output logic                  set_read,
   output logic                  set_write,
   output logic [ADDR_WIDTH-1:0] set_addr,
   output logic [LINE_WIDTH-1:0] set_wdata,
   input  logic                  set_hit,
   input  logic [LINE_WIDTH-1:0] set_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [LINE_WIDTH-1:0] mem_rdata
`ifdef CACHE_REQ_STATS_EN
   ,
   output logic [15:0]           stat_hits,
   output logic [15:0]           stat_misses,
   output logic [15:0]           stat_timeouts
`endif
);

   localparam int             FCW       = $clog2(FILL_TIMEOUT + 1);
   localparam logic [FCW-1:0] FILL_LAST = FCW'(FILL_TIMEOUT - 1);

   ctrl_state_t           state_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic [LINE_WIDTH-1:0] fill_q;
   logic [LINE_WIDTH-1:0] rdata_q;
   logic                  hit_q;
   logic                  err_q;
   logic                  req_ready_q;
   logic                  resp_valid_q;
   logic                  set_enable_q;
   logic                  set_read_q;
   logic                  set_write_q;
   logic                  mem_req_q;
   logic                  mem_we_q;

   // Fill counter holds (FILL cycle index - 1); it is cleared whenever we are
   // outside FILL so every fill starts from zero.
   logic [FCW-1:0] fill_cnt;
   logic           in_fill;
   logic           fill_first;
   logic           fill_hit;
   logic           fill_to;
   logic           fill_done;
   logic           timeout_evt;

   assign in_fill     = (state_q == ST_FILL);
   assign fill_first  = (fill_cnt == '0);
   // The set's hit in the first FILL cycle still reflects the previous operation.
   assign fill_hit    = in_fill && set_hit && !fill_first;
   assign fill_to     = in_fill && (fill_cnt == FILL_LAST);
   assign fill_done   = fill_hit || fill_to;
   // A genuine hit on the last allowed cycle wins over the timeout.
   assign timeout_evt = fill_to && !fill_hit;

   cache_sat_ctr #(.WIDTH(FCW)) u_fill_ctr (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (!in_fill),
      .inc_i (in_fill),
      .cnt_o (fill_cnt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         fill_q       <= '0;
         rdata_q      <= '0;
         hit_q        <= 1'b0;
         err_q        <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         set_enable_q <= 1'b0;
         set_read_q   <= 1'b0;
         set_write_q  <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  we_q        <= req_we;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  rdata_q     <= '0;
                  hit_q       <= 1'b0;
                  err_q       <= 1'b0;
                  req_ready_q <= 1'b0;
                  set_enable_q <= 1'b1;
                  if (req_we) begin
                     fill_q      <= req_wdata;
                     set_write_q <= 1'b1;
                     state_q     <= ST_FILL;
                  end else begin
                     set_read_q  <= 1'b1;
                     state_q     <= ST_LOOKUP;
                  end
               end else begin
                  // Ready rises one cycle after reset release.
                  req_ready_q <= 1'b1;
               end
            end
            ST_LOOKUP: begin
               set_enable_q <= 1'b0;
               set_read_q   <= 1'b0;
               state_q      <= ST_CHECK;
            end
            ST_CHECK: begin
               if (set_hit) begin
                  rdata_q      <= set_rdata;
                  hit_q        <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  mem_req_q <= 1'b1;
                  mem_we_q  <= 1'b0;
                  state_q   <= ST_MEM_RD;
               end
            end
            ST_MEM_RD: begin
               if (mem_ack) begin
                  rdata_q      <= mem_rdata;
                  fill_q       <= mem_rdata;
                  mem_req_q    <= 1'b0;
                  set_enable_q <= 1'b1;
                  set_write_q  <= 1'b1;
                  state_q      <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (fill_done) begin
                  set_enable_q <= 1'b0;
                  set_write_q  <= 1'b0;
                  err_q        <= timeout_evt;
                  if (we_q) begin
                     mem_req_q <= 1'b1;
                     mem_we_q  <= 1'b1;
                     state_q   <= ST_MEM_WR;
                  end else begin
                     resp_valid_q <= 1'b1;
                     state_q      <= ST_RESP;
                  end
               end
            end
            ST_MEM_WR: begin
               if (mem_ack) begin
                  mem_req_q    <= 1'b0;
                  mem_we_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               set_enable_q <= 1'b0;
               set_read_q   <= 1'b0;
               set_write_q  <= 1'b0;
               mem_req_q    <= 1'b0;
               mem_we_q     <= 1'b0;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_hit   = hit_q;
   assign resp_err   = err_q;
   assign set_enable = set_enable_q;
   assign set_read   = set_read_q;
   assign set_write  = set_write_q;
   assign set_addr   = addr_q;
   assign set_wdata  = fill_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;

`ifdef CACHE_REQ_STATS_EN
   cache_sat_ctr #(.WIDTH(16)) u_stat_hits (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (1'b0),
      .inc_i ((state_q == ST_CHECK) && set_hit),
      .cnt_o (stat_hits)
   );

   cache_sat_ctr #(.WIDTH(16)) u_stat_misses (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (1'b0),
      .inc_i ((state_q == ST_CHECK) && !set_hit),
      .cnt_o (stat_misses)
   );

   cache_sat_ctr #(.WIDTH(16)) u_stat_timeouts (
      .clk_i (clock),
      .rst_i (reset),
      .clr_i (1'b0),
      .inc_i (timeout_evt),
      .cnt_o (stat_timeouts)
   );
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Bench for cache_req_ctrl with a behavioural 2-way CLOCK set and a fixed-latency memory.
// Latency: n/a. Backpressure: exercised by holding resp_ready low.
module tb_cache_req_ctrl;

   localparam int KW = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_hit;
   logic        resp_err;
   logic        set_enable, set_read, set_write;
   logic [7:0]  set_addr;
   logic [31:0] set_wdata;
   logic        set_hit;
   logic [31:0] set_rdata;
   logic        mem_req, mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef CACHE_REQ_STATS_EN
   logic [15:0] stat_hits, stat_misses, stat_timeouts;
`endif

   cache_req_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_hit   (resp_hit),
      .resp_err   (resp_err),
      .set_enable (set_enable),
      .set_read   (set_read),
      .set_write  (set_write),
      .set_addr   (set_addr),
      .set_wdata  (set_wdata),
      .set_hit    (set_hit),
      .set_rdata  (set_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
`ifdef CACHE_REQ_STATS_EN
      ,
      .stat_hits     (stat_hits),
      .stat_misses   (stat_misses),
      .stat_timeouts (stat_timeouts)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- behavioural CLOCK set (no reset) ----------------
   logic        s_vld [KW] = '{default: 1'b0};
   logic [7:0]  s_tag [KW] = '{default: 8'h00};
   logic [31:0] s_val [KW] = '{default: 32'h0};
   logic        s_ref [KW] = '{default: 1'b0};
   int          hand = 0;
   logic        s_hit = 1'b0;
   logic [31:0] s_out = '0;
   logic        force_miss = 1'b0;

   assign set_hit   = s_hit & ~force_miss;
   assign set_rdata = s_out;

   function automatic int find_way(input logic [7:0] a);
      for (int w = 0; w < KW; w++) if (s_vld[w] && s_tag[w] == a) return w;
      return -1;
   endfunction

   function automatic int free_way();
      for (int w = 0; w < KW; w++) if (!s_vld[w]) return w;
      return -1;
   endfunction

   always @(posedge clock) begin
      if (set_enable && set_read) begin
         if (find_way(set_addr) >= 0) begin
            s_hit <= 1'b1;
            s_out <= s_val[find_way(set_addr)];
            s_ref[find_way(set_addr)] <= 1'b1;
         end else begin
            s_hit <= 1'b0;
            s_out <= '0;
         end
      end else if (set_enable && set_write) begin
         if (find_way(set_addr) >= 0) begin
            s_val[find_way(set_addr)] <= set_wdata;
            s_ref[find_way(set_addr)] <= 1'b1;
            s_hit <= 1'b1;
         end else if (free_way() >= 0) begin
            s_vld[free_way()] <= 1'b1;
            s_tag[free_way()] <= set_addr;
            s_val[free_way()] <= set_wdata;
            s_ref[free_way()] <= 1'b1;
            s_hit <= 1'b0;
         end else if (s_ref[hand]) begin
            s_ref[hand] <= 1'b0;
            hand  <= (hand + 1) % KW;
            s_hit <= 1'b0;
         end else begin
            s_tag[hand] <= set_addr;
            s_val[hand] <= set_wdata;
            s_ref[hand] <= 1'b1;
            hand  <= (hand + 1) % KW;
            s_hit <= 1'b0;
         end
      end
   end

   // ---------------- backing memory: ack 3 cycles into a request ----------------
   typedef struct { logic [7:0] a; logic [31:0] d; } mw_t;
   mw_t mw_log[$];
   int  mem_cnt = 0;
   int  mem_rd_total = 0;

   function automatic logic [31:0] memval(input logic [7:0] a);
      if (a == 8'h22) return 32'h1234_5678;
      return {16'hC0DE, 8'h00, a};
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_ack <= 1'b0;
         mem_cnt <= 0;
      end else begin
         mem_ack <= 1'b0;
         if (mem_req && !mem_ack) begin
            if (mem_cnt == 2) begin
               mem_ack <= 1'b1;
               mem_cnt <= 0;
               if (mem_we) begin
                  mw_log.push_back('{a: mem_addr, d: mem_wdata});
               end else begin
                  mem_rdata    <= memval(mem_addr);
                  mem_rd_total <= mem_rd_total + 1;
               end
            end else begin
               mem_cnt <= mem_cnt + 1;
            end
         end
      end
   end

   // ---------------- response capture and FILL cycle count ----------------
   typedef struct { logic [31:0] rdata; logic hit; logic err; } rsp_t;
   rsp_t sb_q[$];
   rsp_t act_q[$];
   int   fill_total = 0;

   always @(negedge clock) begin
      if (resp_valid && resp_ready) act_q.push_back('{rdata: resp_rdata, hit: resp_hit, err: resp_err});
      if (set_write) fill_total <= fill_total + 1;
   end

   // ---------------- checking helpers ----------------
   int checks = 0;
   int failures = 0;
   int acc_cyc = 0;
   int resp_cyc = -1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Entered at posedge+2; returns at posedge+2 after the accept edge.
   task automatic send(input logic we, input logic [7:0] a, input logic [31:0] d);
      int g = 0;
      req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
      while (!req_ready && g < 50) begin
         @(posedge clock); #2;
         g++;
      end
      chk("req_accept", 64'(req_ready), 64'd1);
      acc_cyc = cyc;
      @(posedge clock); #2;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int g = 0;
      resp_cyc = -1;
      while (act_q.size() == 0 && g < 400) begin
         @(negedge clock);
         if (resp_valid && resp_cyc < 0) resp_cyc = cyc;
         g++;
      end
      @(posedge clock); #2;
   endtask

   task automatic cmp_resp(input string tag);
      rsp_t a, e;
      chk({tag, "_resp_cnt"}, 64'(act_q.size()), 64'd1);
      if (act_q.size() > 0 && sb_q.size() > 0) begin
         a = act_q.pop_front();
         e = sb_q.pop_front();
         chk({tag, "_rdata"}, 64'(a.rdata), 64'(e.rdata));
         chk({tag, "_hit"},   64'(a.hit),   64'(e.hit));
         chk({tag, "_err"},   64'(a.err),   64'(e.err));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       nm;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_hit;
      logic        exp_err;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int   rd0, fl0;
      rsp_t cap;
      mw_t  mw;

      vecs[0] = '{"w10",     1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
      vecs[1] = '{"r10_hit", 1'b0, 8'h10, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[2] = '{"r22_mis", 1'b0, 8'h22, 32'h0,         32'h1234_5678, 1'b0, 1'b0};
      vecs[3] = '{"r22_hit", 1'b0, 8'h22, 32'h0,         32'h1234_5678, 1'b1, 1'b0};
      vecs[4] = '{"r01_mis", 1'b0, 8'h01, 32'h0,         32'hC0DE_0001, 1'b0, 1'b0};
      vecs[5] = '{"r02_mis", 1'b0, 8'h02, 32'h0,         32'hC0DE_0002, 1'b0, 1'b0};
      vecs[6] = '{"w03_evc", 1'b1, 8'h03, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b0};
      vecs[7] = '{"r03_hit", 1'b0, 8'h03, 32'h0,         32'hA5A5_A5A5, 1'b1, 1'b0};

      // Reset state, sampled while reset is held.
      #3;
      chk("rst_ctrl", {55'b0, req_ready, resp_valid, resp_hit, resp_err, set_enable,
                       set_read, set_write, mem_req, mem_we}, 64'd0);
      chk("rst_data", {resp_rdata, set_wdata}, 64'd0);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #2;

      for (int i = 0; i < 8; i++) begin
         rd0 = mem_rd_total;
         fl0 = fill_total;
         sb_q.push_back('{rdata: vecs[i].exp_rdata, hit: vecs[i].exp_hit, err: vecs[i].exp_err});
         send(vecs[i].we, vecs[i].addr, vecs[i].wdata);
         wait_resp();
         cmp_resp(vecs[i].nm);
         chk({vecs[i].nm, "_memrd"}, 64'(mem_rd_total - rd0),
             (!vecs[i].we && !vecs[i].exp_hit) ? 64'd1 : 64'd0);
         if (vecs[i].exp_hit) chk({vecs[i].nm, "_lat"}, 64'(resp_cyc - acc_cyc), 64'd3);
         if (vecs[i].we) begin
            chk({vecs[i].nm, "_mw_cnt"}, 64'(mw_log.size()), 64'd1);
            if (mw_log.size() > 0) begin
               mw = mw_log.pop_front();
               chk({vecs[i].nm, "_mw_addr"}, 64'(mw.a), 64'(vecs[i].addr));
               chk({vecs[i].nm, "_mw_data"}, 64'(mw.d), 64'(vecs[i].wdata));
            end
         end
         if (i == 6) chk("evict_fill_gt2", 64'((fill_total - fl0) > 2), 64'd1);
      end

      // Backpressure: response held 5 cycles while another request waits.
      resp_ready = 1'b0;
      sb_q.push_back('{rdata: 32'hA5A5_A5A5, hit: 1'b1, err: 1'b0});
      send(1'b0, 8'h03, 32'h0);
      for (int g = 0; g < 50 && !resp_valid; g++) @(negedge clock);
      cap = '{rdata: resp_rdata, hit: resp_hit, err: resp_err};
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_ready", 64'(req_ready), 64'd0);
         chk("bp_rdata", 64'(resp_rdata), 64'(cap.rdata));
         chk("bp_hit",   64'(resp_hit), 64'(cap.hit));
         chk("bp_err",   64'(resp_err), 64'(cap.err));
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      wait_resp();
      cmp_resp("bp");
      repeat (6) @(posedge clock);
      #2;
      chk("bp_no_extra", 64'(act_q.size()), 64'd0);
      chk("bp_idle_ready", 64'(req_ready), 64'd1);

      // Fill timeout: set never reports hit.
      force_miss = 1'b1;
      fl0 = fill_total;
      sb_q.push_back('{rdata: 32'hC0DE_0066, hit: 1'b0, err: 1'b1});
      send(1'b0, 8'h66, 32'h0);
      wait_resp();
      cmp_resp("tmo");
      chk("tmo_fill_cycles", 64'(fill_total - fl0), 64'd8);
      force_miss = 1'b0;
`ifdef CACHE_REQ_STATS_EN
      chk("stat_timeouts", 64'(stat_timeouts), 64'd1);
      chk("stat_hits",     64'(stat_hits),     64'd4);
      chk("stat_misses",   64'(stat_misses),   64'd4);
`endif

      // Reset while the memory read is outstanding.
      send(1'b0, 8'h55, 32'h0);
      for (int g = 0; g < 50 && !mem_req; g++) @(negedge clock);
      chk("mrd_reached", 64'(mem_req), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_ctrl", {55'b0, req_ready, resp_valid, resp_hit, resp_err, set_enable,
                        set_read, set_write, mem_req, mem_we}, 64'd0);
      chk("arst_data", {resp_rdata, mem_wdata}, 64'd0);
      chk("arst_addr", {48'b0, set_addr, mem_addr}, 64'd0);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      repeat (8) @(negedge clock);
      chk("arst_no_resp", 64'(act_q.size()), 64'd0);
      @(posedge clock); #2;
      sb_q.push_back('{rdata: 32'hC0DE_0055, hit: 1'b0, err: 1'b0});
      send(1'b0, 8'h55, 32'h0);
      wait_resp();
      cmp_resp("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_req_ctrl.md
Name: cache_req_ctrl

Overview:
- Request sequencer that sits directly upstream of one K-way CLOCK-replacement cache set.
- Accepts read/write requests from a requester over a valid/ready handshake and drives the set's enable/read/write strobes.
- Holds a write asserted across the set's multi-cycle eviction until the set reports hit.
- Services read misses from backing memory and refills the set; writes are write-through (set then memory). Returns one response per request.

Parameters:
- ADDR_WIDTH, 8, address width; must match the set.
- LINE_WIDTH, 32, data width; must match the set.
- K, 2, associativity of the driven set; used only to size the fill timeout.
- FILL_TIMEOUT, 2*K+4, maximum FILL cycles before the fill is abandoned.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, accepts this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  LINE_WIDTH  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes response.
- resp_rdata  out  LINE_WIDTH  read data; 0 for writes.
- resp_hit  out  1  read hit in set; 0 for misses and writes.
- resp_err  out  1  fill timeout occurred.
- set_enable, set_read, set_write  out  1 each  strobes to the set.
- set_addr  out  ADDR_WIDTH  address to the set.
- set_wdata  out  LINE_WIDTH  data to the set.
- set_hit  in  1  set's registered hit.
- set_rdata  in  LINE_WIDTH  set's registered out_val.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  LINE_WIDTH  valid with mem_ack on reads.

Behaviour:
- Reset: every output is 0, state IDLE, request registers cleared. Reset asserted mid-operation aborts immediately; no response is issued.
- The set has no reset; its residual write state is tolerated by the FILL rules below.
- States: IDLE, LOOKUP, CHECK, MEM_RD, FILL, MEM_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata.
  - Read goes to LOOKUP; write goes to FILL with fill data = req_wdata.
- LOOKUP (1 cycle): set_enable=1, set_read=1, set_addr=latched addr. Next state CHECK.
- CHECK: sample set_hit/set_rdata.
  - Hit: rdata := set_rdata, hit := 1, go to RESP.
  - Miss: go to MEM_RD.
- MEM_RD: mem_req=1, mem_we=0 until mem_ack. Then rdata := mem_rdata, fill data := mem_rdata, go to FILL.
- FILL:
  - set_enable=1, set_write=1, set_read=0.
  - set_hit is ignored in the first FILL cycle, because it is stale.
  - From the 2nd cycle, set_hit=1 ends FILL. Write goes to MEM_WR; read goes to RESP.
  - Fill counter reaching FILL_TIMEOUT ends FILL with err := 1, then same next-state rule.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata until mem_ack, then RESP.
- RESP: resp_valid=1 and outputs held stable until resp_ready; then go to IDLE. resp_valid and req_ready are never both 1.
- Latency: read hit has resp_valid in cycle 3 after the accept edge (cycle 0). Miss and write latencies are variable.
- set_* strobes are 0 in all states not listed. mem_req deasserts in the cycle after mem_ack.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- Counters saturate and never wrap.

Optional Feature:
- Macro: CACHE_REQ_STATS_EN.
- Defined:
  - Adds outputs stat_hits, stat_misses, stat_timeouts, each 16 bits, reset to 0, saturating at 16'hFFFF.
  - stat_hits increments on a CHECK hit. stat_misses increments on a CHECK miss. stat_timeouts increments on a FILL timeout.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - addr_t and val_t, parameterised by the package defaults.
  - ctrl_state_t, an enum of the seven states.
  - The FILL_TIMEOUT default expression.
- One sub-module, cache_sat_ctr (width-parameterised saturating counter with increment and asynchronous reset). It is used for the fill counter and for each statistics counter.

Test Plan:
- Read hit: write 0x10 := 0xDEADBEEF to the set, then read 0x10 -> resp_valid in cycle 3 after accept, rdata=0xDEADBEEF, hit=1, no mem_req.
- Read miss: read 0x22 with empty set, memory returns 0x12345678 after 3 cycles -> one mem read; FILL until set_hit; resp rdata=0x12345678, hit=0. A repeat read of 0x22 then hits.
- Write with eviction (K=2): fill 0x01 and 0x02, then write 0x03 := 0xA5A5A5A5 -> FILL lasts more than 2 cycles; mem write addr=0x03 data=0xA5A5A5A5; resp hit=0, err=0.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp fields stable, req_ready=0, and a new req_valid is not accepted.
- Timeout: stub set_hit=0 permanently -> FILL ends after FILL_TIMEOUT=8 cycles, resp_err=1. With CACHE_REQ_STATS_EN defined, stat_timeouts=1.
- Reset mid-MEM_RD: assert reset while mem_req=1 -> all outputs 0 asynchronously, no response. The next read completes normally.
